// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Recovers hex digits from a multiplexed, active-high 7-segment display bus.
// This is the inverse of the BCD-to-7-segment decoder. It watches the segment
// lines and the one-hot digit enables that a digit scanner drives. A digit is
// accepted only after its {enable, pattern} pair has been stable for a
// programmable dwell. Each accepted pattern is mapped back to a 4-bit code and
// stored in that digit's slot. Once every digit has been seen, the slots are
// published as one frame.
//
// Parameters
//   DIGITS        number of multiplexed digits (1..8)
//   STABLE_CYCLES consecutive matching samples needed before accepting (>=1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in       segment lines, bit6=a .. bit0=g, 1 = lit
//   dig_en       digit selects, active high, expected one-hot
//   value_out    last completed frame, digit i at [4i+3:4i]
//   digit_valid  bit i = last accepted pattern for digit i was legal
//   frame_valid  every digit of the last completed frame was legal
//   frame_strobe one-cycle pulse when value_out is updated
//   err_pattern  one-cycle pulse when an accepted pattern is not in the table
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_en,
  output logic [4*DIGITS-1:0] value_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                frame_valid,
  output logic                frame_strobe,
  output logic                err_pattern
);

  localparam int            CW         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

  // Two-deep sample pipeline: the _q stage is compared against the _p stage.
  logic [6:0]          seg_q;
  logic [6:0]          seg_p;
  logic [DIGITS-1:0]   dig_q;
  logic [DIGITS-1:0]   dig_p;
  logic [CW-1:0]       cnt;

  // Per-digit working slots and the set of digits seen in the current frame.
  logic [4*DIGITS-1:0] slots;
  logic [DIGITS-1:0]   mask;

  logic                match;
  logic                one_hot;
  logic                accept;
  logic [3:0]          code;
  logic                legal;
  logic [4*DIGITS-1:0] next_slots;
  logic [DIGITS-1:0]   next_valid;
  logic                revisit;
  logic                completes;

  // The pins are registered twice with no further synchronisation. The
  // stability counter restarts whenever the two stages disagree. It saturates
  // one step past the accept value, so each dwell is accepted at most once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      seg_p <= '0;
      dig_q <= '0;
      dig_p <= '0;
      cnt   <= '0;
    end else begin
      seg_q <= seg_in;
      seg_p <= seg_q;
      dig_q <= dig_en;
      dig_p <= dig_q;
      if (!match) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A dwell is accepted only when exactly one digit is selected. When no
  // digit is selected, or several are, the counter keeps running but nothing
  // is taken.
  always_comb begin
    match   = (dig_q == dig_p) && (seg_q == seg_p);
    one_hot = (dig_q != '0) && ((dig_q & (dig_q - DIGITS'(1))) == '0);
    accept  = match && (cnt == CNT_ACCEPT) && one_hot;
  end

  // Reverse segment table. Any pattern that is not listed is illegal.
  always_comb begin
    code  = 4'h0;
    legal = 1'b1;
    case (seg_q)
      7'b1111110: code = 4'h0;
      7'b0110000: code = 4'h1;
      7'b1101101: code = 4'h2;
      7'b1111001: code = 4'h3;
      7'b0110011: code = 4'h4;
      7'b1011011: code = 4'h5;
      7'b1011111: code = 4'h6;
      7'b1110000: code = 4'h7;
      7'b1111111: code = 4'h8;
      7'b1111011: code = 4'h9;
      7'b0001101: code = 4'hA;
      7'b0011001: code = 4'hB;
      7'b0100011: code = 4'hC;
      7'b1001011: code = 4'hD;
      7'b0001111: code = 4'hE;
      7'b0000000: code = 4'hF;
      default: begin
        code  = 4'h0;
        legal = 1'b0;
      end
    endcase
  end

  // This is the slot and valid view with the current sample merged in. A
  // completing accept publishes this merged view, so the newest nibble lands
  // in value_out on the same edge.
  always_comb begin
    next_slots = slots;
    next_valid = digit_valid;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[i]) begin
        next_slots[4*i +: 4] = legal ? code : 4'h0;
        next_valid[i]        = legal;
      end
    end
    revisit   = (mask & dig_q) != '0;
    completes = !revisit && ((mask | dig_q) == {DIGITS{1'b1}});
  end

  // Frame assembly. If a digit is seen twice before the frame completes, the
  // scan is assumed to have restarted. The frame then begins again from that
  // digit. Both pulses clear on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots        <= '0;
      mask         <= '0;
      value_out    <= '0;
      digit_valid  <= '0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
      err_pattern  <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      err_pattern  <= 1'b0;
      if (accept) begin
        slots       <= next_slots;
        digit_valid <= next_valid;
        err_pattern <= !legal;
        if (revisit) begin
          mask <= dig_q;
        end else if (completes) begin
          value_out    <= next_slots;
          frame_valid  <= &next_valid;
          frame_strobe <= 1'b1;
          mask         <= '0;
        end else begin
          mask <= mask | dig_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Self-checking bench for seg7_scan_decoder. It uses two instances: a 4-digit
// one and a 1-digit one, both with STABLE_CYCLES=4. Each test pushes its
// expected frames into a per-instance queue. A negedge monitor pops a frame
// and compares it on every frame_strobe. The monitor also counts strobes and
// error pulses, and the tests check those counts.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4_n;
  logic [6:0]  seg4;
  logic [3:0]  dig4;
  logic [15:0] value4;
  logic [3:0]  dvalid4;
  logic        fvalid4;
  logic        strobe4;
  logic        err4;

  logic        rst1_n;
  logic [6:0]  seg1;
  logic [0:0]  dig1;
  logic [3:0]  value1;
  logic [0:0]  dvalid1;
  logic        fvalid1;
  logic        strobe1;
  logic        err1;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst4_n),
    .seg_in       (seg4),
    .dig_en       (dig4),
    .value_out    (value4),
    .digit_valid  (dvalid4),
    .frame_valid  (fvalid4),
    .frame_strobe (strobe4),
    .err_pattern  (err4)
  );

  seg7_scan_decoder #(.DIGITS(1), .STABLE_CYCLES(4)) dut1 (
    .clk          (clk),
    .rst_n        (rst1_n),
    .seg_in       (seg1),
    .dig_en       (dig1),
    .value_out    (value1),
    .digit_valid  (dvalid1),
    .frame_valid  (fvalid1),
    .frame_strobe (strobe1),
    .err_pattern  (err1)
  );

  typedef struct packed {
    logic [15:0] value;
    logic        fvalid;
    logic [3:0]  dvalid;
  } frame_t;

  frame_t exp4_q[$];
  frame_t exp1_q[$];
  frame_t want4;
  frame_t want1;
  frame_t got4;
  frame_t got1;

  int tests_run    = 0;
  int tests_failed = 0;
  int strobe_cnt4  = 0;
  int err_cnt4     = 0;
  int both_cnt4    = 0;
  int strobe_cnt1  = 0;
  int err_cnt1     = 0;

  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b0001101, 7'b0011001,
                           7'b0100011, 7'b1001011, 7'b0001111, 7'b0000000};

  function automatic frame_t mk(input logic [15:0] v, input logic fv, input logic [3:0] dv);
    frame_t f;
    f.value  = v;
    f.fvalid = fv;
    f.dvalid = dv;
    return f;
  endfunction

  // Scoreboard side for the 4-digit instance. Every strobe must match the
  // oldest outstanding expected frame.
  always @(negedge clk) begin
    if (err4) err_cnt4++;
    if (strobe4) begin
      strobe_cnt4++;
      if (err4) both_cnt4++;
      got4 = mk(value4, fvalid4, dvalid4);
      tests_run++;
      if (exp4_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL frame4_unexpected: got %h, no frame expected", got4);
      end else begin
        want4 = exp4_q.pop_front();
        if (got4 !== want4) begin
          tests_failed++;
          $display("[TB] FAIL frame4: value=%h fvalid=%b dvalid=%b, want value=%h fvalid=%b dvalid=%b",
                   got4.value, got4.fvalid, got4.dvalid, want4.value, want4.fvalid, want4.dvalid);
        end
      end
    end
  end

  // Scoreboard side for the single-digit instance.
  always @(negedge clk) begin
    if (err1) err_cnt1++;
    if (strobe1) begin
      strobe_cnt1++;
      got1 = mk({12'h000, value1}, fvalid1, {3'b000, dvalid1});
      tests_run++;
      if (exp1_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL frame1_unexpected: got %h, no frame expected", got1);
      end else begin
        want1 = exp1_q.pop_front();
        if (got1 !== want1) begin
          tests_failed++;
          $display("[TB] FAIL frame1: value=%h fvalid=%b dvalid=%b, want value=%h fvalid=%b dvalid=%b",
                   got1.value, got1.fvalid, got1.dvalid, want1.value, want1.fvalid, want1.dvalid);
        end
      end
    end
  end

  // Advance to just after the n-th following negedge, so the monitors have
  // already run for that edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic dwell4(input logic [3:0] d, input logic [6:0] s, input int n);
    dig4 = d;
    seg4 = s;
    tick(n);
  endtask

  task automatic dwell1(input logic [6:0] s, input int n);
    dig1 = 1'b1;
    seg1 = s;
    tick(n);
  endtask

  task automatic reset4();
    dig4   = '0;
    seg4   = '0;
    rst4_n = 1'b0;
    tick(2);
    exp4_q.delete();
    rst4_n = 1'b1;
    tick(2);
  endtask

  task automatic reset1();
    dig1   = '0;
    seg1   = '0;
    rst1_n = 1'b0;
    tick(2);
    exp1_q.delete();
    rst1_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    int s4;
    int s1;
    $display("[TB] test_reset");
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seg4 = 7'($urandom);
      dig4 = 4'($urandom);
      seg1 = 7'($urandom);
      dig1 = 1'($urandom);
      tick(1);
      tests_run++;
      if ({value4, dvalid4, fvalid4, strobe4, err4} !== 23'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset4_hold: outputs=%h want 0", {value4, dvalid4, fvalid4, strobe4, err4});
      end
      tests_run++;
      if ({value1, dvalid1, fvalid1, strobe1, err1} !== 8'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset1_hold: outputs=%h want 0", {value1, dvalid1, fvalid1, strobe1, err1});
      end
    end
    s4 = strobe_cnt4;
    s1 = strobe_cnt1;
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    dig4   = '0;
    dig1   = '0;
    for (int c = 0; c < 20; c++) begin
      seg4 = 7'($urandom);
      seg1 = 7'($urandom);
      tick(1);
      tests_run++;
      if ({value4, dvalid4, fvalid4, strobe4, err4, value1, dvalid1, fvalid1, strobe1, err1} !== 31'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle: dut4=%h dut1=%h want 0",
                 {value4, dvalid4, fvalid4, strobe4, err4}, {value1, dvalid1, fvalid1, strobe1, err1});
      end
    end
    tests_run++;
    if ((strobe_cnt4 - s4) + (strobe_cnt1 - s1) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %0d strobes want 0", (strobe_cnt4 - s4) + (strobe_cnt1 - s1));
    end
  endtask

  task automatic test_frame();
    int s0;
    int e0;
    $display("[TB] test_frame");
    reset4();
    s0 = strobe_cnt4;
    e0 = err_cnt4;
    exp4_q.push_back(mk(16'h4321, 1'b1, 4'b1111));
    dwell4(4'b0001, 7'b0110000, 10);
    dwell4(4'b0010, 7'b1101101, 10);
    dwell4(4'b0100, 7'b1111001, 10);
    dwell4(4'b1000, 7'b0110011, 10);
    dwell4(4'b0000, 7'b0000000, 8);
    tests_run++;
    if (strobe_cnt4 - s0 !== 1 || exp4_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL frame_count: got %0d strobes (%0d pending) want 1 (0)", strobe_cnt4 - s0, exp4_q.size());
    end
    tests_run++;
    if (err_cnt4 - e0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL frame_err: got %0d err pulses want 0", err_cnt4 - e0);
    end
    tests_run++;
    if (value4 !== 16'h4321 || fvalid4 !== 1'b1 || dvalid4 !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL frame_hold: value=%h fvalid=%b dvalid=%b want 4321 1 1111", value4, fvalid4, dvalid4);
    end
  endtask

  task automatic test_glitch();
    int s0;
    int e0;
    $display("[TB] test_glitch");
    reset4();
    s0 = strobe_cnt4;
    e0 = err_cnt4;
    dwell4(4'b0001, 7'b0110000, 4);
    dig4 = 4'b0001;
    seg4 = 7'b1111110;
    tick(5);
    tests_run++;
    if (dvalid4 !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL glitch_early: dvalid=%b want 0000 after 5 edges", dvalid4);
    end
    tick(1);
    tests_run++;
    if (dvalid4 !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL glitch_accept: dvalid=%b want 0001 at edge 6", dvalid4);
    end
    tick(4);
    dwell4(4'b0011, 7'b1111110, 20);
    tests_run++;
    if (dvalid4 !== 4'b0001 || strobe_cnt4 - s0 !== 0 || err_cnt4 - e0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_multihot: dvalid=%b strobes=%0d errs=%0d want 0001 0 0",
               dvalid4, strobe_cnt4 - s0, err_cnt4 - e0);
    end
    exp4_q.push_back(mk(16'h9650, 1'b1, 4'b1111));
    dwell4(4'b0010, 7'b1011011, 10);
    dwell4(4'b0100, 7'b1011111, 10);
    dwell4(4'b1000, 7'b1111011, 10);
    tests_run++;
    if (strobe_cnt4 - s0 !== 1 || exp4_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_frame: got %0d strobes want 1", strobe_cnt4 - s0);
    end
  endtask

  task automatic test_illegal();
    int s0;
    int e0;
    int b0;
    $display("[TB] test_illegal");
    reset4();
    s0 = strobe_cnt4;
    e0 = err_cnt4;
    b0 = both_cnt4;
    exp4_q.push_back(mk(16'h4021, 1'b0, 4'b1011));
    dwell4(4'b0001, 7'b0110000, 10);
    dwell4(4'b0010, 7'b1101101, 10);
    dwell4(4'b1000, 7'b0110011, 10);
    dwell4(4'b0100, 7'b1000001, 10);
    tests_run++;
    if (err_cnt4 - e0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_err: got %0d err cycles want 1", err_cnt4 - e0);
    end
    tests_run++;
    if (strobe_cnt4 - s0 !== 1 || both_cnt4 - b0 !== 1 || exp4_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_frame: strobes=%0d coincident=%0d want 1 1", strobe_cnt4 - s0, both_cnt4 - b0);
    end
    tests_run++;
    if (dvalid4 !== 4'b1011 || fvalid4 !== 1'b0 || value4 !== 16'h4021) begin
      tests_failed++;
      $display("[TB] FAIL illegal_hold: value=%h fvalid=%b dvalid=%b want 4021 0 1011", value4, fvalid4, dvalid4);
    end
  endtask

  task automatic test_revisit();
    int s0;
    $display("[TB] test_revisit");
    reset4();
    s0 = strobe_cnt4;
    exp4_q.push_back(mk(16'hDCBA, 1'b1, 4'b1111));
    dwell4(4'b0001, 7'b1110000, 10);
    dwell4(4'b0010, 7'b1111111, 10);
    dwell4(4'b0001, 7'b0001101, 10);
    dwell4(4'b0010, 7'b0011001, 10);
    tests_run++;
    if (strobe_cnt4 - s0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL revisit_early: got %0d strobes want 0", strobe_cnt4 - s0);
    end
    dwell4(4'b0100, 7'b0100011, 10);
    dwell4(4'b1000, 7'b1001011, 10);
    tests_run++;
    if (strobe_cnt4 - s0 !== 1 || exp4_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL revisit_frame: got %0d strobes want 1", strobe_cnt4 - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    $display("[TB] test_back_to_back");
    s0 = strobe_cnt4;
    exp4_q.push_back(mk(16'h0123, 1'b1, 4'b1111));
    dwell4(4'b1000, 7'b1111110, 10);
    dwell4(4'b0100, 7'b0110000, 10);
    dwell4(4'b0010, 7'b1101101, 10);
    dwell4(4'b0001, 7'b1111001, 10);
    tests_run++;
    if (strobe_cnt4 - s0 !== 1 || exp4_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: got %0d strobes want 1", strobe_cnt4 - s0);
    end
  endtask

  task automatic test_single_digit();
    int s0;
    int e0;
    $display("[TB] test_single_digit");
    reset1();
    s0 = strobe_cnt1;
    e0 = err_cnt1;
    for (int i = 0; i < 16; i++) begin
      exp1_q.push_back(mk({12'h000, 4'(i)}, 1'b1, 4'b0001));
      dwell1(pat[i], 8);
    end
    tests_run++;
    if (strobe_cnt1 - s0 !== 16 || exp1_q.size() !== 0 || err_cnt1 - e0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL single_frames: strobes=%0d pending=%0d errs=%0d want 16 0 0",
               strobe_cnt1 - s0, exp1_q.size(), err_cnt1 - e0);
    end
    s0 = strobe_cnt1;
    dig1 = 1'b1;
    seg1 = pat[5];
    tick(2);
    rst1_n = 1'b0;
    #1;
    tests_run++;
    if ({value1, dvalid1, fvalid1} !== 6'h0) begin
      tests_failed++;
      $display("[TB] FAIL single_reset: value=%h dvalid=%b fvalid=%b want 0 0 0", value1, dvalid1, fvalid1);
    end
    tick(2);
    rst1_n = 1'b1;
    tick(4);
    tests_run++;
    if (strobe_cnt1 - s0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL single_reset_dwell: got %0d strobes want 0", strobe_cnt1 - s0);
    end
    exp1_q.push_back(mk(16'h0009, 1'b1, 4'b0001));
    dwell1(pat[9], 8);
    tests_run++;
    if (strobe_cnt1 - s0 !== 1 || exp1_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL single_recover: got %0d strobes want 1", strobe_cnt1 - s0);
    end
  endtask

  initial begin
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    seg4   = '0;
    dig4   = '0;
    seg1   = '0;
    dig1   = '0;
    tick(1);
    test_reset();
    test_frame();
    test_glitch();
    test_illegal();
    test_revisit();
    test_back_to_back();
    test_single_digit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Recovers hex digits from a multiplexed, active-high 7-segment display bus. This is the inverse of the codebase's BCD-to-7-segment decoder.
- Samples the segment lines and one-hot digit enables, and accepts a digit only after its pattern has been stable for a programmable dwell.
- Maps each accepted pattern back to a 4-bit code and assembles a complete multi-digit frame.
- Used as a display monitor and self-check path on boards that drive the segment decoder through a digit scanner.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, number of consecutive matching samples required before a digit is accepted (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines, bit6=a down to bit0=g, 1 = segment lit.
- dig_en  input  DIGITS  digit select, active high, expected one-hot; bit i selects digit i.
- value_out  output  4*DIGITS  last completed frame; digit i at [4i+3:4i].
- digit_valid  output  DIGITS  bit i = last accepted pattern for digit i was legal.
- frame_valid  output  1  all digits of the last completed frame were legal.
- frame_strobe  output  1  one-cycle pulse when value_out is updated.
- err_pattern  output  1  one-cycle pulse when an accepted pattern is not in the table.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, every output and internal register is 0: value_out, digit_valid, frame_valid, frame_strobe, err_pattern, sample registers, stability counter and frame mask.
- Input stage:
  - seg_q/dig_q register the pins every clock.
  - seg_p/dig_p register seg_q/dig_q every clock.
  - No further synchronisation.
- Stability counter:
  - cnt is ceil(log2(STABLE_CYCLES+1)) bits.
  - Mismatch between {dig_q,seg_q} and {dig_p,seg_p}: cnt<=0.
  - Match and cnt<STABLE_CYCLES: cnt<=cnt+1.
  - Saturates at STABLE_CYCLES.
- Accept condition: match AND cnt==STABLE_CYCLES-1 AND dig_q exactly one-hot.
  - Fires at most once per dwell, because cnt saturates past the accept value.
  - dig_q all-zero or multi-hot never accepts; the counter still runs.
- Latency: pins settled before edge 1 are accepted at edge STABLE_CYCLES+2, e.g. edge 6 for the default.
- Decode table (abcdefg -> code):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3
  - 0110011->4, 1011011->5, 1011111->6, 1110000->7
  - 1111111->8, 1111011->9, 0001101->A, 0011001->B
  - 0100011->C, 1001011->D, 0001111->E, 0000000 (blank)->F
- At the accept edge, for selected digit i:
  - Legal pattern: slot[i]<=code, digit_valid[i]<=1.
  - Any other pattern: slot[i]<=0, digit_valid[i]<=0, err_pattern<=1 for one cycle.
- Frame state: mask of digits accepted in the current frame.
  - Accept of digit i with mask[i]=0: mask[i]<=1.
  - Accept of digit i with mask[i]=1 (revisit before completion): mask<=only bit i; frame restarts, no strobe.
  - Accept that completes the mask (all DIGITS bits set), at the same edge:
    - value_out<=slots with the new nibble merged in.
    - frame_valid<=AND of digit_valid including the new result.
    - frame_strobe<=1; mask<=0.
  - frame_strobe clears at the next edge.
  - value_out and frame_valid hold between strobes.
- DIGITS=1: every accept completes a frame.
- Reset asserted mid-dwell or mid-frame: partial frame discarded, no strobe produced.
- Simultaneous error and frame completion: err_pattern and frame_strobe pulse in the same cycle, with frame_valid=0.

Test Plan:
1. Reset: hold rst_n=0 with random pins, then release with dig_en=0 for 20 cycles -> all outputs 0, no strobe.
2. DIGITS=4, STABLE_CYCLES=4: dwell 10 cycles each on dig_en=0001/0110000, 0010/1101101, 0100/1111001, 1000/0110011 -> single frame_strobe, value_out=16'h4321, frame_valid=1, digit_valid=4'b1111.
3. Glitch filtering: dig_en=0001 with seg 0110000 for 4 cycles, then 1111110 for 10 cycles -> only code 0 accepted, exactly at edge 6 after the change; dig_en=0011 for 20 cycles -> no accept.
4. Illegal pattern 1000001 on digit 2 within an otherwise legal frame -> err_pattern one pulse, digit_valid[2]=0, nibble 2 = 0, frame_strobe with frame_valid=0.
5. Revisit: digit order 0,1,0,1,2,3 (legal patterns) -> exactly one frame_strobe, after digit 3; the first digit-1 accept does not complete a frame.
6. DIGITS=1: step through all 16 table patterns with 8-cycle dwells -> 16 strobes with value_out 0..F in order; assert rst_n low in cycle 3 of a dwell -> outputs 0, and no strobe for that dwell.
